cv32e40s_instr_obi_arbiter: RTL

- Shares one instruction-side OBI transaction port (trans_*/resp_*) between two requesters: req0, the prefetcher, and req1, the secondary fetch source (debug/table-jump fetch).
- Performs round-robin arbitration and limits the number of outstanding transactions to MAX_OUTSTANDING.
- Records which requester owns each accepted transaction in an in-order ID FIFO and routes each response back to that requester.
- Sits between the fetch sources and the instruction OBI interface adapter.

---
 rtl/cv32e40s_pkg.sv | 15 +
 rtl/cv32e40s_instr_obi_id_fifo.sv | 71 +++++++
 rtl/cv32e40s_instr_obi_arbiter.sv | 124 ++++++++++++
 3 files changed

// File: rtl/cv32e40s_pkg.sv
// Shared types and helpers for the instruction-side OBI arbiter slice.
package cv32e40s_pkg;

   // Owner of an instruction-side OBI transaction
   typedef enum logic {
      ARB_REQ0 = 1'b0,   // prefetcher
      ARB_REQ1 = 1'b1    // secondary fetch source (debug / table jump)
   } arb_id_e;

   // Pointer width for a circular buffer of the given depth (at least 1 bit)
   function automatic int unsigned ptr_width(input int unsigned depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/cv32e40s_instr_obi_id_fifo.sv
// In-order FIFO of 1-bit requester IDs for outstanding OBI transactions.
// Pointers wrap explicitly at DEPTH-1, so non power-of-2 depths are exact.
module cv32e40s_instr_obi_id_fifo
   import cv32e40s_pkg::*;
#(
   parameter int unsigned DEPTH = 2
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic push_i,
   input  logic push_id_i,
   input  logic pop_i,
   output logic empty_o,
   output logic full_o,
   output logic head_o
);

   localparam int unsigned      PTR_W = ptr_width(DEPTH);
   localparam logic [PTR_W-1:0] LAST  = PTR_W'(DEPTH - 1);

   logic [DEPTH-1:0] mem_q, mem_d;
   logic [PTR_W-1:0] wptr_q, wptr_d;
   logic [PTR_W-1:0] rptr_q, rptr_d;
   logic             full_q, full_d;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      return (ptr == LAST) ? '0 : ptr + PTR_W'(1);
   endfunction

   // Next-state: write at wptr on push, advance rptr on pop, track full flag
   always_comb begin
      mem_d  = mem_q;
      wptr_d = wptr_q;
      rptr_d = rptr_q;
      full_d = full_q;
      if (push_i) begin
         mem_d[wptr_q] = push_id_i;
         wptr_d        = next_ptr(wptr_q);
      end
      if (pop_i) begin
         rptr_d = next_ptr(rptr_q);
      end
      // Equal pointers are ambiguous; the flag records which way they met
      if (push_i && !pop_i) begin
         full_d = (next_ptr(wptr_q) == rptr_q);
      end else if (pop_i && !push_i) begin
         full_d = 1'b0;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q  <= '0;
         wptr_q <= '0;
         rptr_q <= '0;
         full_q <= 1'b0;
      end else begin
         mem_q  <= mem_d;
         wptr_q <= wptr_d;
         rptr_q <= rptr_d;
         full_q <= full_d;
      end
   end

   assign empty_o = (rptr_q == wptr_q) && !full_q;
   assign full_o  = full_q;
   assign head_o  = mem_q[rptr_q];

endmodule

// File: rtl/cv32e40s_instr_obi_arbiter.sv
// Round-robin arbiter sharing one instruction OBI port between the prefetcher
// (req0) and the secondary fetch source (req1), with an outstanding limit and
// in-order response routing via an ID FIFO.
module cv32e40s_instr_obi_arbiter
   import cv32e40s_pkg::*;
#(
   parameter int unsigned MAX_OUTSTANDING = 2,
   parameter int unsigned REQ_W           = 40,
   parameter int unsigned RESP_W          = 36
)
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req0_valid_i,
   output logic              req0_ready_o,
   input  logic [REQ_W-1:0]  req0_i,
   input  logic              req1_valid_i,
   output logic              req1_ready_o,
   input  logic [REQ_W-1:0]  req1_i,
   output logic              resp0_valid_o,
   output logic              resp1_valid_o,
   output logic [RESP_W-1:0] resp_o,
   output logic              trans_valid_o,
   input  logic              trans_ready_i,
   output logic [REQ_W-1:0]  trans_o,
   input  logic              resp_valid_i,
   input  logic [RESP_W-1:0] resp_i,
   output logic              protocol_err_o
);

   localparam int unsigned     CNT_W   = $clog2(MAX_OUTSTANDING + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   arb_id_e          rr_q, rr_d;
   arb_id_e          sel_q, sel_d;
   logic             lock_q, lock_d;
   arb_id_e          sel;
   logic             can_issue;
   logic             accept;
   logic             pop;
   logic             fifo_empty;
   logic             fifo_full;
   logic             fifo_head;

   // FIFO occupancy always equals cnt_q; the full flag is a redundant guard
   assign can_issue = (cnt_q < CNT_MAX) && !fifo_full;

   // Requester selection: locked choice, else single valid, else round-robin
   always_comb begin
      sel = ARB_REQ0;
      if (lock_q) begin
         sel = sel_q;
      end else if (req0_valid_i && !req1_valid_i) begin
         sel = ARB_REQ0;
      end else if (req1_valid_i && !req0_valid_i) begin
         sel = ARB_REQ1;
      end else if (req0_valid_i && req1_valid_i) begin
         sel = (rr_q == ARB_REQ0) ? ARB_REQ1 : ARB_REQ0;
      end
   end

   assign trans_valid_o = can_issue && (lock_q || req0_valid_i || req1_valid_i);
   assign trans_o       = (sel == ARB_REQ1) ? req1_i : req0_i;
   assign accept        = trans_valid_o && trans_ready_i;
   assign req0_ready_o  = accept && (sel == ARB_REQ0);
   assign req1_ready_o  = accept && (sel == ARB_REQ1);

   // Response routing and spurious-response detection
   assign pop            = resp_valid_i && !fifo_empty;
   assign protocol_err_o = resp_valid_i && fifo_empty;
   assign resp0_valid_o  = pop && (fifo_head == ARB_REQ0);
   assign resp1_valid_o  = pop && (fifo_head == ARB_REQ1);
   assign resp_o         = resp_i;

   // Next-state: outstanding count, round-robin pointer and back-pressure lock
   always_comb begin
      cnt_d  = cnt_q;
      rr_d   = rr_q;
      sel_d  = sel_q;
      lock_d = lock_q;
      if (accept && !pop) begin
         cnt_d = cnt_q + CNT_W'(1);
      end else if (pop && !accept) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
      if (accept) begin
         rr_d   = sel;
         lock_d = 1'b0;
      end else if (trans_valid_o) begin
         lock_d = 1'b1;
         sel_d  = sel;
      end
   end

   // State registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         rr_q   <= ARB_REQ1;
         sel_q  <= ARB_REQ0;
         lock_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         rr_q   <= rr_d;
         sel_q  <= sel_d;
         lock_q <= lock_d;
      end
   end

   cv32e40s_instr_obi_id_fifo #(
      .DEPTH (MAX_OUTSTANDING)
   ) u_id_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push_i    (accept),
      .push_id_i (sel),
      .pop_i     (pop),
      .empty_o   (fifo_empty),
      .full_o    (fifo_full),
      .head_o    (fifo_head)
   );

endmodule
